// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, response and controller-side signals of mem_arbiter
interface mem_arbiter_if;
  logic        Halt;
  logic        Halted;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IAck;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DData;
  logic [1:0]  DByteEn;
  logic        DSignExt;
  logic        DAck;
  logic [31:0] RspData;
  logic        RspErr;
  logic        Ready;
  logic        Execute;
  logic        DataWe;
  logic [31:0] Address;
  logic [31:0] InData;
  logic [1:0]  DataByteEn;
  logic        SignExtend;
  logic [31:0] OutData;
  logic        DataReady;

  modport master (
    input  Halt, IReq, IAddr, DReq, DWe, DAddr, DData, DByteEn, DSignExt,
           Ready, OutData, DataReady,
    output Halted, IAck, DAck, RspData, RspErr, Execute, DataWe, Address,
           InData, DataByteEn, SignExtend
  );

  modport slave (
    output Halt, IReq, IAddr, DReq, DWe, DAddr, DData, DByteEn, DSignExt,
           Ready, OutData, DataReady,
    input  Halted, IAck, DAck, RspData, RspErr, Execute, DataWe, Address,
           InData, DataByteEn, SignExtend
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter onto one memory controller port
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           Clk,
  input logic           Reset,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        grant_i;
  logic        last_i;
  logic        pick_i;
  logic        execute;
  logic        iack;
  logic        dack;
  logic        rsp_err;
  logic        data_we;
  logic        sign_ext;
  logic [31:0] address;
  logic [31:0] in_data;
  logic [31:0] rsp_data;
  logic [1:0]  byte_en;

  // On a tie the requester not served last wins; last_i resets to 0 (data side).
  assign pick_i = bus.IReq && (!bus.DReq || !last_i);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      grant_i  <= 1'b0;
      last_i   <= 1'b0;
      execute  <= 1'b0;
      iack     <= 1'b0;
      dack     <= 1'b0;
      rsp_err  <= 1'b0;
      data_we  <= 1'b0;
      sign_ext <= 1'b0;
      address  <= 32'd0;
      in_data  <= 32'd0;
      rsp_data <= 32'd0;
      byte_en  <= 2'd0;
    end else begin
      execute <= 1'b0;
      iack    <= 1'b0;
      dack    <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.Halt && bus.Ready && (bus.IReq || bus.DReq)) begin
            state   <= ISSUE;
            execute <= 1'b1;
            grant_i <= pick_i;
            if (pick_i) begin
              address  <= bus.IAddr;
              in_data  <= 32'd0;
              data_we  <= 1'b0;
              byte_en  <= 2'd2;
              sign_ext <= 1'b0;
            end else begin
              address  <= bus.DAddr;
              in_data  <= bus.DData;
              data_we  <= bus.DWe;
              byte_en  <= bus.DByteEn;
              sign_ext <= bus.DSignExt;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= 16'd0;
        end
        WAIT: begin
          if (bus.DataReady) begin
            state    <= RESP;
            rsp_data <= bus.OutData;
            rsp_err  <= 1'b0;
            iack     <= grant_i;
            dack     <= !grant_i;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            state    <= RESP;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b1;
            iack     <= grant_i;
            dack     <= !grant_i;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          last_i <= grant_i;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Halted     = bus.Halt && (state == IDLE);
  assign bus.Execute    = execute;
  assign bus.IAck       = iack;
  assign bus.DAck       = dack;
  assign bus.RspData    = rsp_data;
  assign bus.RspErr     = rsp_err;
  assign bus.DataWe     = data_we;
  assign bus.Address    = address;
  assign bus.InData     = in_data;
  assign bus.DataByteEn = byte_en;
  assign bus.SignExtend = sign_ext;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int TIMEOUT = 4;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  bit   last_was_d;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: winner from request set and last winner; ack cycle from the response delay.
  task automatic do_txn(input bit ri, input bit rd, input int r, input int d);
    bit          win_i;
    bit          err;
    int          ack_c;
    int          bad;
    logic [31:0] exp_addr;
    logic [31:0] exp_in;
    logic [31:0] rsp;
    logic        exp_we;
    logic        exp_se;
    logic [1:0]  exp_be;
    win_i    = ri && (!rd || last_was_d);
    err      = (d >= TIMEOUT);
    ack_c    = err ? r + TIMEOUT + 2 : r + d + 3;
    rsp      = $urandom;
    exp_addr = win_i ? bus.IAddr : bus.DAddr;
    exp_in   = bus.DData;
    exp_we   = win_i ? 1'b0 : bus.DWe;
    exp_be   = win_i ? 2'd2 : bus.DByteEn;
    exp_se   = win_i ? 1'b0 : bus.DSignExt;
    bad      = 0;
    bus.IReq = ri;
    bus.DReq = rd;
    for (int c = 0; c <= ack_c; c++) begin
      if (c > 0) begin
        if (bus.Execute !== (c == r + 1)) bad++;
        if (bus.IAck !== (c == ack_c && win_i)) bad++;
        if (bus.DAck !== (c == ack_c && !win_i)) bad++;
        if (bus.Halted !== 1'b0) bad++;
        if (c == r + 1) begin
          check("exec_addr", bus.Address, exp_addr);
          check("exec_we", 32'(bus.DataWe), 32'(exp_we));
          check("exec_byteen", 32'(bus.DataByteEn), 32'(exp_be));
          check("exec_sext", 32'(bus.SignExtend), 32'(exp_se));
          if (!win_i) check("exec_wdata", bus.InData, exp_in);
        end
      end
      if (c < ack_c) begin
        bus.Ready     = (c >= r);
        bus.DataReady = (c == r + 2 + d);
        bus.OutData   = (c == r + 2 + d) ? rsp : $urandom;
        if (c > r) begin
          bus.IAddr = $urandom;
          bus.DAddr = $urandom;
          bus.DData = $urandom;
        end
        tick();
      end
    end
    check("ack_data", bus.RspData, err ? 32'h0 : rsp);
    check("ack_err", 32'(bus.RspErr), 32'(err));
    check("addr_held", bus.Address, exp_addr);
    check("txn_timing", 32'(bad), 32'd0);
    bus.IReq      = 1'b0;
    bus.DReq      = 1'b0;
    bus.DataReady = 1'b0;
    bus.Ready     = 1'b1;
    last_was_d    = !win_i;
    tick();
  endtask

  initial begin
    int          bad;
    int          nexec;
    int          sel;
    bit          win;
    logic [31:0] first_addr;

    checks = 0;
    errors = 0;
    last_was_d = 1'b1;
    first_addr = 32'h0;
    bus.Halt = 1'b1;
    bus.IReq = 1'b0;
    bus.IAddr = 32'h0;
    bus.DReq = 1'b0;
    bus.DWe = 1'b0;
    bus.DAddr = 32'h0;
    bus.DData = 32'h0;
    bus.DByteEn = 2'd0;
    bus.DSignExt = 1'b0;
    bus.Ready = 1'b1;
    bus.OutData = 32'h0;
    bus.DataReady = 1'b0;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    check("rst_halted", 32'(bus.Halted), 32'd1);
    check("rst_strobes", 32'({bus.Execute, bus.IAck, bus.DAck, bus.RspErr}), 32'd0);
    check("rst_cmd_bits", 32'({bus.DataWe, bus.SignExtend, bus.DataByteEn}), 32'd0);
    check("rst_address", bus.Address, 32'h0);
    check("rst_indata", bus.InData, 32'h0);
    check("rst_rspdata", bus.RspData, 32'h0);
    bus.Halt = 1'b0;
    #1;
    check("rst_halted_follows", 32'(bus.Halted), 32'd0);
    tick();
    tick();
    Reset = 1'b1;
    tick();

    bus.DAddr = 32'h100;
    bus.DByteEn = 2'd2;
    bus.DWe = 1'b0;
    do_txn(1'b0, 1'b1, 0, 1);

    bus.IAddr = 32'h400;
    bus.DAddr = 32'h800;
    bus.IReq = 1'b1;
    bus.DReq = 1'b1;
    bus.DataReady = 1'b1;
    bus.OutData = 32'h5A5A5A5A;
    bad = 0;
    nexec = 0;
    win = last_was_d;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) first_addr = bus.Address;
      if (bus.Execute) nexec++;
      if (bus.Execute !== (c % 4 == 1)) bad++;
      if ((c % 4 == 1) && bus.Address !== (win ? 32'h400 : 32'h800)) bad++;
      if (bus.IAck !== (c % 4 == 3 && win)) bad++;
      if (bus.DAck !== (c % 4 == 3 && !win)) bad++;
      if (c % 4 == 3) begin
        last_was_d = !win;
        win = !win;
      end
    end
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
    bus.DataReady = 1'b0;
    check("tie_first_fetch", first_addr, 32'h400);
    check("tie_exec_count", 32'(nexec), 32'd4);
    check("tie_sequence", 32'(bad), 32'd0);

    bus.DWe = 1'b1;
    bus.DAddr = 32'h180;
    bus.DData = 32'h12345678;
    bus.DByteEn = 2'd1;
    do_txn(1'b0, 1'b1, 0, 2);
    bus.IAddr = 32'h40;
    do_txn(1'b1, 1'b0, 1, 0);

    bus.IAddr = 32'h200;
    do_txn(1'b1, 1'b0, 0, TIMEOUT);
    bus.DataReady = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.IAck !== 1'b0 || bus.DAck !== 1'b0 || bus.Execute !== 1'b0) bad++;
    end
    bus.DataReady = 1'b0;
    check("late_dataready_ignored", 32'(bad), 32'd0);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(1, 3);
      bus.IAddr = $urandom;
      bus.DAddr = $urandom;
      bus.DData = $urandom;
      bus.DWe = 1'($urandom_range(0, 1));
      bus.DSignExt = 1'($urandom_range(0, 1));
      bus.DByteEn = 2'($urandom_range(0, 2));
      do_txn(sel[0], sel[1], $urandom_range(0, 2), $urandom_range(0, TIMEOUT + 1));
    end

    bus.DReq = 1'b1;
    bus.DWe = 1'b0;
    bus.DAddr = 32'h300;
    bus.DByteEn = 2'd2;
    tick();
    tick();
    bus.Halt = 1'b1;
    bus.IReq = 1'b1;
    bus.IAddr = 32'h700;
    tick();
    check("halt_in_wait", 32'(bus.Halted), 32'd0);
    bus.DataReady = 1'b1;
    bus.OutData = 32'hCAFE0001;
    tick();
    check("halt_dack", 32'(bus.DAck), 32'd1);
    check("halt_rspdata", bus.RspData, 32'hCAFE0001);
    bus.DataReady = 1'b0;
    bus.DReq = 1'b0;
    tick();
    check("halted_idle", 32'(bus.Halted), 32'd1);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.Execute !== 1'b0 || bus.Halted !== 1'b1) bad++;
    end
    check("halt_blocks_grant", 32'(bad), 32'd0);
    bus.Halt = 1'b0;
    tick();
    check("unhalt_execute", 32'(bus.Execute), 32'd1);
    check("unhalt_addr", bus.Address, 32'h700);
    bus.DataReady = 1'b1;
    tick();
    tick();
    check("unhalt_iack", 32'(bus.IAck), 32'd1);
    bus.IReq = 1'b0;
    bus.DataReady = 1'b0;
    last_was_d = 1'b0;
    tick();

    bus.IAddr = 32'h900;
    bus.DAddr = 32'hA00;
    bus.IReq = 1'b1;
    bus.DReq = 1'b1;
    tick();
    check("pre_reset_grant_d", bus.Address, 32'hA00);
    tick();
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_address", bus.Address, 32'h0);
    check("async_rst_cmd", 32'({bus.Execute, bus.DataByteEn, bus.Halted}), 32'd0);
    bus.DataReady = 1'b1;
    bad = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.IAck !== 1'b0 || bus.DAck !== 1'b0 || bus.Execute !== 1'b0) bad++;
    end
    check("reset_no_ack", 32'(bad), 32'd0);
    bus.DataReady = 1'b0;
    Reset = 1'b1;
    tick();
    check("post_reset_exec", 32'(bus.Execute), 32'd1);
    check("post_reset_fetch_first", bus.Address, 32'h900);
    bus.DataReady = 1'b1;
    tick();
    tick();
    check("post_reset_iack", 32'(bus.IAck), 32'd1);
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
    bus.DataReady = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single `mem_controller` port between instruction fetch and load/store traffic inside `core`. Sequences one transaction at a time onto the controller's Ready/Execute/DataReady handshake. Grants alternate round-robin on contention, with a halt gate for `Halted` and a watchdog that terminates hung transactions with an error.

## Interface
- `TIMEOUT`, default 255: cycles spent in WAIT without `DataReady` before forced error completion; range 1..65535.
- `Clk` input 1: sole clock, rising edge.
- `Reset` input 1: asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `Halt` input 1: blocks new grants; an in-flight transaction completes.
- `Halted` output 1: high when `Halt`=1 and state is IDLE.
- `IReq` input 1: fetch request, held until `IAck`.
- `IAddr` input 32: fetch address; always word read, no sign extension.
- `IAck` output 1: one-cycle completion pulse to fetch.
- `DReq` input 1: load/store request, held until `DAck`.
- `DWe` input 1: 1 store, 0 load.
- `DAddr` input 32: data address.
- `DData` input 32: store data.
- `DByteEn` input 2: size encoding, 0 byte, 1 half, 2 word.
- `DSignExt` input 1: sign-extend loads.
- `DAck` output 1: one-cycle completion pulse to load/store.
- `RspData` output 32: read data, valid during the ack pulse.
- `RspErr` output 1: timeout flag, valid during the ack pulse.
- `Ready` input 1: the controller can accept a command.
- `Execute` output 1: one-cycle command strobe.
- `DataWe` output 1: write enable to the controller.
- `Address` output 32: address to the controller.
- `InData` output 32: write data to the controller.
- `DataByteEn` output 2: size to the controller.
- `SignExtend` output 1: sign-extension select to the controller.
- `OutData` input 32: read data from the controller.
- `DataReady` input 1: completion strobe from the controller.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when `Halt`=0, `Ready`=1 and (`IReq` or `DReq`). The winner's fields are latched into registers that drive `Address`/`InData`/`DataWe`/`DataByteEn`/`SignExtend`. For fetch, the latched values are `DataWe`=0, `DataByteEn`=2, `SignExtend`=0.
- Arbitration: if only one request is present, it wins. If both are present, the requester not granted last wins. `LastGrant` resets to D, so fetch wins the first tie.
- ISSUE: `Execute`=1 for exactly this cycle; next state is WAIT. The timeout counter is cleared.
- WAIT: when `DataReady`=1, latch `OutData` into `RspData`, set `RspErr`=0, go to RESP. Otherwise the counter increments. When the counter equals `TIMEOUT`-1 without `DataReady`, set `RspData`=0, `RspErr`=1, go to RESP.
- RESP: pulse `IAck` or `DAck` for the granted requester, update `LastGrant`, go to IDLE. There is no arbitration in the RESP cycle.
- `DataReady` outside WAIT is ignored, including a late completion after a timeout.
- Latched command fields hold their value until the next grant. Requester inputs are not sampled after the grant.
- If `Halt` rises during ISSUE or WAIT, the transaction completes normally; `Halted` asserts on the first IDLE cycle.
- Assertion of `Reset` at any time:
  - state returns to IDLE and the counter clears;
  - outputs take their reset values immediately, so an in-flight transaction is abandoned with no ack;
  - `LastGrant` returns to D.
- Reset values:
  - `Execute`, `IAck`, `DAck`, `RspErr`, `DataWe`, `SignExtend`: 0.
  - `Address`, `InData`, `RspData`: 0.
  - `DataByteEn`: 0.
  - `Halted`: equals `Halt`, since the state is IDLE.

## Timing
- Request sampled in IDLE at cycle 0; `Execute` high at cycle 1.
- If `DataReady` is high at cycle k (k≥2), ack is high at cycle k+1 and the state is IDLE at cycle k+2. Minimum request-to-ack latency is 3 cycles.
- Back-to-back throughput: at most one transaction per 4 cycles.
- Timeout ack arrives at cycle 1+`TIMEOUT`+1 after the grant cycle.
- Requester protocol: `Req` and its fields must stay stable until the ack. `Req` may drop in the ack cycle or stay high to request again. Request again is re-arbitrated in the next IDLE cycle.
- `IAck` and `DAck` are never high together, and each is never high for two consecutive cycles.

## Test plan
- Single load: `DReq`, `DAddr`=0x100, `DByteEn`=2, `DataReady` at cycle 3 with `OutData`=0xDEADBEEF:
  - `Execute` is high at cycle 1 with `Address`=0x100;
  - `DAck` and `RspData`=0xDEADBEEF are high at cycle 4;
  - `RspErr`=0.
- Simultaneous `IReq`/`DReq` held high for 4 transactions after reset: grant order is I, D, I, D, each with exactly one `Execute` and one ack.
- Store: `DWe`=1, `DData`=0x12345678, `DByteEn`=1: `Execute` cycle shows `DataWe`=1, `InData`=0x12345678, `DataByteEn`=1. A fetch issued afterwards shows `DataWe`=0, `DataByteEn`=2.
- Timeout with `TIMEOUT`=4 and no `DataReady`: the ack arrives 6 cycles after the grant with `RspErr`=1 and `RspData`=0. A `DataReady` one cycle later produces no ack.
- Halt:
  - `Halt`=1 while in WAIT: the transaction acks, then `Halted`=1 and no `Execute` occurs despite a pending `IReq`;
  - when `Halt` drops, `Execute` follows 1 cycle later.
- `Reset` low mid-WAIT: `Execute`, acks and the state clear asynchronously. After release with `IReq`/`DReq` both high, fetch is granted first.
